// File: rtl/regfile_write_demux.sv
// Write side of the 32 x 32-bit register file: registered one-hot decode stage, commit stage and bulk clear.
// Build option: define REG0_ZERO_EN to hardwire register 0 to zero (writes to it still handshake normally).
module regfile_write_demux (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [4:0]    wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          clr_req,
    output logic          wr_done,
    output logic          clr_busy,
    output logic [31:0]   wr_onehot,
    output logic [1023:0] regs
);

`ifdef REG0_ZERO_EN
    localparam bit REG0_HARD = 1'b1;
`else
    localparam bit REG0_HARD = 1'b0;
`endif

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t             state_r;
    logic [4:0]         cnt_r;
    logic [31:0]        data_r;
    logic [31:0][31:0]  regs_r;
    logic               accept_s;

    assign wr_ready = (state_r == IDLE) && !clr_req;
    assign accept_s = wr_valid && wr_ready;
    assign regs     = regs_r;

    // Control FSM: IDLE accepts writes, CLEAR walks cnt_r across all registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= 5'd0;
            clr_busy <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (clr_req) begin
                        state_r  <= CLEAR;
                        cnt_r    <= 5'd0;
                        clr_busy <= 1'b1;
                    end else begin
                        state_r  <= IDLE;
                        cnt_r    <= cnt_r;
                        clr_busy <= 1'b0;
                    end
                end
                CLEAR: begin
                    cnt_r <= cnt_r + 5'd1;
                    if (cnt_r == 5'd31) begin
                        state_r  <= IDLE;
                        clr_busy <= 1'b0;
                    end else begin
                        state_r  <= CLEAR;
                        clr_busy <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    cnt_r    <= 5'd0;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: capture decoded address and data; wr_done flags the commit one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_onehot <= 32'd0;
            data_r    <= 32'd0;
            wr_done   <= 1'b0;
        end else begin
            wr_done <= |wr_onehot;
            if (accept_s) begin
                wr_onehot <= 32'd1 << wr_addr;
                data_r    <= wr_data;
            end else begin
                wr_onehot <= 32'd0;
                data_r    <= data_r;
            end
        end
    end

    // Register array: commit from stage 1, or zero the register under the clear counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_r <= '0;
        end else begin
            for (int k = 0; k < 32; k++) begin
                if (REG0_HARD && (k == 0)) begin
                    regs_r[k] <= 32'd0;
                end else if (wr_onehot[k]) begin
                    regs_r[k] <= data_r;
                end else if ((state_r == CLEAR) && (cnt_r == 5'(k))) begin
                    regs_r[k] <= 32'd0;
                end else begin
                    regs_r[k] <= regs_r[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_demux.sv
// Randomized and directed bench for regfile_write_demux against an edge-numbered reference model.
// Define REG0_ZERO_EN identically for bench and design to check the hardwired-zero build.
module tb_regfile_write_demux;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [4:0]    wr_addr = 5'd0;
    logic [31:0]   wr_data = 32'd0;
    logic          clr_req = 1'b0;
    logic          wr_done;
    logic          clr_busy;
    logic [31:0]   wr_onehot;
    logic [1023:0] regs;

    regfile_write_demux dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req), .wr_done(wr_done),
        .clr_busy(clr_busy), .wr_onehot(wr_onehot), .regs(regs)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: writes are scheduled by the edge number on which they land;
    // a clear requested at edge clr_m zeroes register k at edge clr_m+1+k.
    typedef struct {
        int          e;
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic [31:0] m_regs [32];
    wr_t         pend [$];
    int          edge_no = 0;
    int          clr_m = -1000;
    logic        m_done = 1'b0;
    logic [31:0] m_onehot = 32'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit in_clear(input int e);
        return (e > clr_m) && (e <= clr_m + 32);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
        pend.delete();
        clr_m    = -1000;
        m_done   = 1'b0;
        m_onehot = 32'd0;
    endtask

    task automatic check_all();
        for (int k = 0; k < 32; k++)
            check($sformatf("reg%0d", k), 64'(regs[32*k +: 32]), 64'(m_regs[k]));
        check("wr_done", 64'(wr_done), 64'(m_done));
        check("wr_onehot", 64'(wr_onehot), 64'(m_onehot));
        check("clr_busy", 64'(clr_busy), 64'(in_clear(edge_no + 1)));
    endtask

    task automatic step(input bit v, input int a, input logic [31:0] d, input bit c);
        int e;
        bit rdy;
        bit acc;
        wr_valid = v;
        wr_addr  = a[4:0];
        wr_data  = d;
        clr_req  = c;
        #1;
        e   = edge_no + 1;
        rdy = !in_clear(e) && !c;
        check("wr_ready", 64'(wr_ready), 64'(rdy));
        acc = v && rdy;
        @(posedge clk);
        #1;
        edge_no = e;
        m_done  = 1'b0;
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].e == e) begin
                m_regs[pend[i].addr] = pend[i].data;
                m_done = 1'b1;
                pend.delete(i);
            end
        end
        if (in_clear(e)) m_regs[e - clr_m - 1] = 32'd0;
        else if (c) clr_m = e;
        if (acc) pend.push_back('{e + 1, a, d});
        m_onehot = acc ? (32'd1 << a) : 32'd0;
`ifdef REG0_ZERO_EN
        m_regs[0] = 32'd0;
`endif
        check_all();
    endtask

    task automatic do_reset();
        wr_valid = 1'b0;
        clr_req  = 1'b0;
        rst_n    = 1'b0;
        #1;
        model_reset();
        check_all();
        check("wr_ready_rst", 64'(wr_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [31:0] exp0;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // single write to address 5, then idle
        step(1'b1, 5, 32'hDEADBEEF, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 32'd0, 1'b0);
        check("reg5_direct", 64'(regs[191:160]), 64'h0000_0000_DEAD_BEEF);

        // back-to-back writes to 1..31
        for (int a = 1; a < 32; a++) step(1'b1, a, 32'(a) * 32'h01010101, 1'b0);
        step(1'b0, 0, 32'd0, 1'b0);
        for (int k = 1; k < 32; k++)
            check($sformatf("b2b_reg%0d", k), 64'(regs[32*k +: 32]), 64'(32'(k) * 32'h01010101));

        // write to address 0
        step(1'b1, 0, 32'h12345678, 1'b0);
        step(1'b0, 0, 32'd0, 1'b0);
`ifdef REG0_ZERO_EN
        exp0 = 32'd0;
`else
        exp0 = 32'h12345678;
`endif
        check("reg0_direct", 64'(regs[31:0]), 64'(exp0));

        // clear raised while a write to 7 is pending
        step(1'b1, 7, 32'h7777_0007, 1'b0);
        step(1'b0, 0, 32'd0, 1'b1);
        check("reg7_before_clear", 64'(regs[255:224]), 64'h0000_0000_7777_0007);
        for (int i = 0; i < 33; i++) step(1'b1, i % 32, 32'hBAD0_0000 + 32'(i), 1'b0);
        step(1'b0, 0, 32'd0, 1'b0);

        // clear and write together: clear wins
        for (int a = 1; a < 8; a++) step(1'b1, a, 32'hC0DE_0000 + 32'(a), 1'b0);
        step(1'b1, 3, 32'hAAAA5555, 1'b1);
        for (int i = 0; i < 33; i++) step(1'b0, 0, 32'd0, 1'b0);
        check("reg3_not_written", 64'(regs[127:96]), 64'd0);

        // reset during clear once cnt has reached 10
        for (int a = 1; a < 32; a++) step(1'b1, a, 32'hF00D_0000 + 32'(a), 1'b0);
        step(1'b0, 0, 32'd0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 0, 32'd0, 1'b0);
        do_reset();
        step(1'b0, 0, 32'd0, 1'b0);

        // randomized traffic, with one asynchronous reset in the middle
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            step($urandom_range(0, 9) < 7, int'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 39) == 0);
        end
        for (int i = 0; i < 34; i++) step(1'b0, 0, 32'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
